// File: rtl/radix4_booth_pkg.sv
// Shared types and helpers for the radix-4 Booth accumulator.
// State encoding, digit/width helpers and the digit weighting term.
package radix4_booth_pkg;

  localparam int BOOTH_MAXP = 128;

  typedef enum logic {
    ACCUM,
    DONE
  } booth_acc_state_t;

  function automatic int booth_num_digits(input int width);
    return width / 2;
  endfunction

  function automatic int booth_pp_width(input int width);
    return width + 2;
  endfunction

  // Sign-extended partial product weighted by 4^dig.
  function automatic logic [BOOTH_MAXP-1:0] booth_weight_pp(
    input logic [BOOTH_MAXP-1:0] pp,
    input logic [7:0]            dig
  );
    return pp << {dig, 1'b0};
  endfunction

endpackage

// File: rtl/radix4_booth_accumulator.sv
// Radix-4 Booth partial-product accumulator (valid/ready in and out).
// Optional macro RADIX4_BOOTH_ACC_EARLY_ACCEPT_EN overlaps handoff with digit 0.
module radix4_booth_accumulator
  import radix4_booth_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHECK_PARAM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pp_valid,
  output logic               pp_ready,
  input  logic [WIDTH+1:0]   pp_data,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod_data
);

  localparam int NDIG = booth_num_digits(WIDTH);
  localparam int PW   = booth_pp_width(WIDTH);
  localparam int PRW  = 2 * WIDTH;
  localparam int CW   = $clog2(NDIG) + 1;

  if (CHECK_PARAM != 0 && (WIDTH < 2 || (WIDTH % 2) != 0)) begin : g_bad_width
    $fatal(1, "radix4_booth_accumulator: WIDTH must be even and >= 2");
  end

  booth_acc_state_t state;
  logic [CW-1:0]    cnt;
  logic [PRW-1:0]   acc;

  logic [BOOTH_MAXP-1:0] pp_ext;
  logic [PRW-1:0]        term;

  assign pp_ext = {{(BOOTH_MAXP-PW){pp_data[PW-1]}}, pp_data};
  assign term   = PRW'(booth_weight_pp(pp_ext, 8'(cnt)));

  assign prod_valid = (state == DONE);
  assign prod_data  = acc;

`ifdef RADIX4_BOOTH_ACC_EARLY_ACCEPT_EN
  assign pp_ready = (state == ACCUM) || prod_ready;
`else
  assign pp_ready = (state == ACCUM);
`endif

  // Digit accumulation and product handoff FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (pp_valid) begin
            acc <= acc + term;
            if (cnt == CW'(NDIG - 1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (prod_ready) begin
`ifdef RADIX4_BOOTH_ACC_EARLY_ACCEPT_EN
            if (pp_valid) begin
              acc <= term;
              if (NDIG == 1) begin
                state <= DONE;
                cnt   <= '0;
              end else begin
                state <= ACCUM;
                cnt   <= CW'(1);
              end
            end else begin
              acc   <= '0;
              state <= ACCUM;
            end
`else
            acc   <= '0;
            state <= ACCUM;
`endif
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: doc/radix4_booth_accumulator.md
Name: radix4_booth_accumulator

Overview:
Consumer end of the radix-4 Booth encoded-partial-product interface.
- Accepts WIDTH/2 encoded partial products (each WIDTH+2 bits, signed), least-significant Booth digit first, over a valid/ready handshake.
- Weights each digit by 4^i, accumulates into a 2*WIDTH signed product, and presents the product on a second valid/ready interface.
- Sits directly after the Booth encoder array in the sequential multiplier datapath.

Parameters:
WIDTH, 8, multiplicand and multiplier width; must be even and >= 2; product is 2*WIDTH bits
CHECK_PARAM, 1, if 1 the build fails ($fatal) when WIDTH is 0 or odd

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
pp_valid  input  1  pp_data holds a valid encoded partial product
pp_ready  output  1  block accepts pp_data this cycle
pp_data  input  WIDTH+2  signed encoded partial product for the current digit (0, +/-M, +/-2M)
prod_valid  output  1  prod_data holds a completed product
prod_ready  input  1  downstream accepts prod_data
prod_data  output  2*WIDTH  signed product multiplicand*multiplier, two's complement

Behaviour:
- Constant NDIG = WIDTH/2. Digit counter cnt, width $clog2(NDIG)+1. Accumulator acc, 2*WIDTH bits.
- States: ACCUM, DONE.
- Reset (rst_n low, asynchronous):
  - state=ACCUM, cnt=0, acc=0.
  - Outputs: prod_valid=0, prod_data=0, pp_ready=1.
  - Reset mid-operation discards any partial accumulation; no product is emitted for it.
- ACCUM:
  - pp_ready=1, prod_valid=0.
  - On pp_valid&&pp_ready: acc <= acc + (sext(pp_data, 2*WIDTH) << 2*cnt), addition modulo 2^(2*WIDTH); cnt <= cnt+1.
  - If cnt==NDIG-1 at acceptance: state <= DONE, cnt <= 0.
  - pp_valid low: no change; gaps of any length are allowed between digits.
- DONE:
  - prod_valid=1, prod_data=acc, pp_ready=0 (base build).
  - prod_data stays stable while prod_ready=0.
  - On prod_ready=1: acc <= 0, state <= ACCUM.
- prod_data is driven from acc.
- Latency: prod_valid asserts the cycle after the final digit is accepted.
- Base-build throughput: one product every NDIG+1 cycles at best.
- Result is exact for all signed inputs, including the -2^(WIDTH-1) * -2^(WIDTH-1) corner; no overflow flag.
- pp_data in ACCUM is never checked for legality; any WIDTH+2 value is accumulated as given.
- Digits are unlabeled. The producer guarantees order; the block trusts cnt only.

Optional Feature:
Macro RADIX4_BOOTH_ACC_EARLY_ACCEPT_EN.
- Defined:
  - In DONE, pp_ready = prod_ready.
  - If prod_ready && pp_valid in DONE: the product is handed off and the first digit of the next product is accepted in the same cycle; acc <= sext(pp_data), cnt <= 1, state <= ACCUM.
  - If NDIG==1, state stays DONE with prod_data = new product.
  - Throughput: one product per NDIG cycles.
- Undefined: pp_ready=0 in DONE, as in the base behaviour.

Decomposition:
- Package radix4_booth_pkg holds:
  - enum type booth_acc_state_t {ACCUM, DONE};
  - function booth_num_digits(width) returning width/2;
  - function booth_pp_width(width) returning width+2.
- No sub-module is required. The shift-and-sign-extend term is a local function in the package (booth_weight_pp).

Test Plan (WIDTH=8):
1. Multiplicand 7, multiplier 3: send digits -7, +7, 0, 0 (pp_data 0x3F9, 0x007, 0, 0), prod_ready=1 -> prod_valid the cycle after the 4th accept, prod_data=0x0015, then pp_ready=1.
2. Multiplicand -128, multiplier -128: send digits 0, 0, 0, +256 (0x100) -> prod_data=0x4000.
3. Hold prod_ready=0 for 5 cycles after completion, with pp_valid=1 throughout -> prod_data held at its value, pp_ready=0, no digit consumed; product drains on the prod_ready rising edge.
4. Randomized pp_valid gaps (0-3 idle cycles) for multiplicand -5, multiplier 27 -> prod_data=0xFF79 (-135); cnt unaffected by idle cycles.
5. Reset mid-operation: accept 2 digits, pulse rst_n low asynchronously, then send the full sequence for 7x3 -> prod_data=0x0015, no spurious prod_valid.
6. With RADIX4_BOOTH_ACC_EARLY_ACCEPT_EN: back-to-back 7x3 then 7x3 with prod_ready=1 -> second prod_valid exactly 4 cycles after the first, both 0x0015.
